// File: rtl/ifetch_pkg.sv
// Shared widths, the fetch-entry record and the PC-to-index mapping for the
// instruction fetch stage.
package ifetch_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // icache is halfword-addressed; the byte PC's bit 0 is dropped
  function automatic logic [ADDR_W-1:0] pc_to_index(input logic [ADDR_W-1:0] pc);
    return pc >> 1;
  endfunction
endpackage

// File: rtl/ifetch_if.sv
// Bundle of the icache request/response, branch redirect and decode
// handshake signals seen by the fetch stage.
interface ifetch_if;
  import ifetch_pkg::*;

  logic               icache_not_enable;
  logic [ADDR_W-1:0]  icache_index;
  logic [INSTR_W-1:0] icache_data;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output icache_not_enable, icache_index, out_valid, out_instr, out_pc,
    input  icache_data, branch_valid, branch_target, out_ready
  );

  modport slave (
    input  icache_not_enable, icache_index, out_valid, out_instr, out_pc,
    output icache_data, branch_valid, branch_target, out_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and a registered head
// so the decode-facing outputs come straight from flops.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);
  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] cnt;
  fetch_entry_t     head_q;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (cnt != '0) && !flush;
  assign rd_nxt  = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Head tracks the oldest entry: a push lands here directly when the FIFO is
  // (or is about to become) empty, otherwise a pop advances to the next slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else if (do_push && ((cnt == '0) || (do_pop && cnt == CNT_W'(1)))) begin
      head_q <= push_entry;
    end else if (do_pop && cnt > CNT_W'(1)) begin
      head_q <= mem[rd_nxt];
    end
  end

  assign count = cnt;
  assign head  = head_q;
endmodule

// File: rtl/ifetch.sv
// Thumb instruction fetch: owns the PC, issues icache reads, absorbs the
// one-cycle read latency and hands {instr, pc} to decode via valid/ready.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  ifetch_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc, target_pc, req_pc_p1;
  logic              vld_p1, issue, push, pop;
  logic [CNT_W-1:0]  count;
  logic [SUM_W-1:0]  demand, room;
  fetch_entry_t      push_entry, head;

  // stage p0: request issue
  assign target_pc = bus.branch_target & ~ADDR_W'(1);
  assign pop       = (count != '0) && bus.out_ready;
  // occupancy + inflight - pop < DEPTH, kept non-negative by moving pop across
  assign demand    = SUM_W'(count) + SUM_W'(vld_p1);
  assign room      = SUM_W'(FIFO_DEPTH) + SUM_W'(pop);
  assign issue     = !rst && (bus.branch_valid || (demand < room));

  assign bus.icache_not_enable = !issue;
  assign bus.icache_index      = pc_to_index(bus.branch_valid ? target_pc : fetch_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC & ~ADDR_W'(1);
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (bus.branch_valid) begin
        fetch_pc <= target_pc + ADDR_W'(PC_STEP);
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= bus.branch_valid ? target_pc : fetch_pc;
  end

  // stage p1: icache response captured into the output FIFO
  assign push             = vld_p1 && !bus.branch_valid && !rst;
  assign push_entry.instr = bus.icache_data;
  assign push_entry.pc    = req_pc_p1;

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.branch_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  // stage p2: registered FIFO head presented to decode
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed cycle tables, a wrap-around sequence and a
// randomized run checked against an instruction-stream model.
module tb_ifetch;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ifetch_if bus0();
  ifetch_if bus1();

  ifetch #(.RESET_PC(32'h0000_0014), .FIFO_DEPTH(2)) dut0 (
    .clk (clk), .rst (rst0), .bus (bus0.master)
  );
  ifetch #(.RESET_PC(32'hFFFF_FFFE), .FIFO_DEPTH(2)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1.master)
  );

  // icache contents as a function of halfword index
  function automatic logic [15:0] icache_word(input logic [31:0] idx);
    case (idx)
      32'd10:  return 16'h0123;
      32'd11:  return 16'h4567;
      32'd12:  return 16'h89AB;
      32'd13:  return 16'hCDEF;
      default: return idx[15:0] ^ idx[31:16] ^ 16'hA55A;
    endcase
  endfunction

  // one-cycle-latency icache
  always @(posedge clk) begin
    if (!bus0.icache_not_enable) bus0.icache_data <= icache_word(bus0.icache_index);
    if (!bus1.icache_not_enable) bus1.icache_data <= icache_word(bus1.icache_index);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rs, rdy, brv;
    logic [31:0] tgt;
    logic        cv, ev;
    logic [15:0] ei;
    logic [31:0] ep;
    logic        en;
    logic [31:0] eidx;
  } vec_t;

  function automatic vec_t row(input logic rs, rdy, brv, input logic [31:0] tgt,
                               input logic cv, ev, input logic [15:0] ei,
                               input logic [31:0] ep, input logic en,
                               input logic [31:0] eidx);
    vec_t r;
    r.rs = rs; r.rdy = rdy; r.brv = brv; r.tgt = tgt; r.cv = cv; r.ev = ev;
    r.ei = ei; r.ep = ep; r.en = en; r.eidx = eidx;
    return r;
  endfunction

  vec_t vecs[$];

  logic [31:0] exp_pc, hold_pc;
  logic [15:0] hold_instr;
  logic        post_flush, hold_chk, r_rst, r_brv, r_rdy;
  logic [31:0] r_tgt;
  int          gap;

  initial begin
    bus0.branch_valid = 1'b0; bus0.branch_target = '0; bus0.out_ready = 1'b1;
    bus1.branch_valid = 1'b0; bus1.branch_target = '0; bus1.out_ready = 1'b1;

    // reset, streaming, branch to 0x19 with a pop and an in-flight response
    vecs.push_back(row(1,1,0,0,           0,0,0,0,          1,0));
    vecs.push_back(row(1,1,0,0,           1,0,0,0,          1,0));
    vecs.push_back(row(0,1,0,0,           1,0,0,0,          0,32'hA));
    vecs.push_back(row(0,1,0,0,           1,0,0,0,          0,32'hB));
    vecs.push_back(row(0,1,0,0,           1,1,16'h0123,32'h14, 0,32'hC));
    vecs.push_back(row(0,1,0,0,           1,1,16'h4567,32'h16, 0,32'hD));
    vecs.push_back(row(0,1,0,0,           1,1,16'h89AB,32'h18, 0,32'hE));
    vecs.push_back(row(0,1,0,0,           1,1,16'hCDEF,32'h1A, 0,32'hF));
    vecs.push_back(row(0,1,1,32'h19,      1,1,16'hA554,32'h1C, 0,32'hC));
    vecs.push_back(row(0,1,0,0,           1,0,0,0,          0,32'hD));
    vecs.push_back(row(0,1,0,0,           1,1,16'h89AB,32'h18, 0,32'hE));
    vecs.push_back(row(0,1,0,0,           1,1,16'hCDEF,32'h1A, 0,32'hF));
    // back-pressure: FIFO fills, fetch stops, then drains without loss
    vecs.push_back(row(1,0,0,0,           0,0,0,0,          1,0));
    vecs.push_back(row(0,0,0,0,           1,0,0,0,          0,32'hA));
    vecs.push_back(row(0,0,0,0,           1,0,0,0,          0,32'hB));
    vecs.push_back(row(0,0,0,0,           1,1,16'h0123,32'h14, 1,0));
    vecs.push_back(row(0,0,0,0,           1,1,16'h0123,32'h14, 1,0));
    vecs.push_back(row(0,0,0,0,           1,1,16'h0123,32'h14, 1,0));
    vecs.push_back(row(0,1,0,0,           1,1,16'h0123,32'h14, 0,32'hC));
    vecs.push_back(row(0,1,0,0,           1,1,16'h4567,32'h16, 0,32'hD));
    vecs.push_back(row(0,1,0,0,           1,1,16'h89AB,32'h18, 0,32'hE));
    vecs.push_back(row(0,1,0,0,           1,1,16'hCDEF,32'h1A, 0,32'hF));
    // single-cycle reset mid-stream
    vecs.push_back(row(0,1,0,0,           1,1,16'hA554,32'h1C, 0,32'h10));
    vecs.push_back(row(1,1,0,0,           1,1,16'hA555,32'h1E, 1,0));
    vecs.push_back(row(0,1,0,0,           1,0,0,0,          0,32'hA));
    vecs.push_back(row(0,1,0,0,           1,0,0,0,          0,32'hB));
    vecs.push_back(row(0,1,0,0,           1,1,16'h0123,32'h14, 0,32'hC));
    vecs.push_back(row(0,1,0,0,           1,1,16'h4567,32'h16, 0,32'hD));

    for (int i = 0; i < vecs.size(); i++) begin
      rst0 = vecs[i].rs;
      bus0.out_ready = vecs[i].rdy;
      bus0.branch_valid = vecs[i].brv;
      bus0.branch_target = vecs[i].tgt;
      @(negedge clk);
      chk($sformatf("v%0d not_enable", i), bus0.icache_not_enable, vecs[i].en);
      if (!vecs[i].en) chk($sformatf("v%0d index", i), bus0.icache_index, vecs[i].eidx);
      if (vecs[i].cv) begin
        chk($sformatf("v%0d out_valid", i), bus0.out_valid, vecs[i].ev);
        if (vecs[i].ev) begin
          chk($sformatf("v%0d out_instr", i), bus0.out_instr, vecs[i].ei);
          chk($sformatf("v%0d out_pc", i), bus0.out_pc, vecs[i].ep);
        end else if (vecs[i].rs) begin
          chk("reset out_instr", bus0.out_instr, 0);
          chk("reset out_pc", bus0.out_pc, 0);
        end
      end
      @(posedge clk); #1;
    end
    bus0.branch_valid = 1'b0;

    // PC wrap on the second instance
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap reset out_valid", bus1.out_valid, 0);
    chk("wrap reset not_enable", bus1.icache_not_enable, 1);
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    chk("wrap idx0", bus1.icache_index, 32'h7FFF_FFFF);
    chk("wrap nen0", bus1.icache_not_enable, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap idx1", bus1.icache_index, 32'h0000_0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap valid0", bus1.out_valid, 1);
    chk("wrap pc0", bus1.out_pc, 32'hFFFF_FFFE);
    chk("wrap instr0", bus1.out_instr, icache_word(32'h7FFF_FFFF));
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap pc1", bus1.out_pc, 32'h0000_0000);
    chk("wrap instr1", bus1.out_instr, icache_word(32'h0));
    @(posedge clk); #1;

    // randomized run against an in-order instruction-stream model
    exp_pc = 32'h14; post_flush = 1'b0; hold_chk = 1'b0; gap = 0;
    hold_pc = '0; hold_instr = '0;
    for (int k = 0; k < 3000; k++) begin
      r_rst = (k == 0) || ($urandom_range(0, 199) == 0);
      r_brv = !r_rst && ($urandom_range(0, 19) == 0);
      r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h7)) : $urandom;
      r_rdy = ($urandom_range(0, 9) < 7);
      rst0 = r_rst; bus0.branch_valid = r_brv; bus0.branch_target = r_tgt; bus0.out_ready = r_rdy;
      @(negedge clk);
      if (post_flush) chk("rnd empty after flush", bus0.out_valid, 0);
      if (hold_chk) begin
        chk("rnd hold valid", bus0.out_valid, 1);
        chk("rnd hold pc", bus0.out_pc, hold_pc);
        chk("rnd hold instr", bus0.out_instr, hold_instr);
      end
      if (r_brv) begin
        chk("rnd branch index", bus0.icache_index, r_tgt >> 1);
        chk("rnd branch nen", bus0.icache_not_enable, 0);
      end
      if (!r_rst && bus0.out_valid && r_rdy) begin
        chk("rnd stream pc", bus0.out_pc, exp_pc);
        chk("rnd stream instr", bus0.out_instr, icache_word(exp_pc >> 1));
        exp_pc = exp_pc + 32'd2;
      end
      if (r_rst) gap = 0;
      else if (bus0.out_valid) gap = 0;
      else begin
        gap++;
        if (gap > 3) chk("rnd output starved", gap, 3);
      end
      if (r_brv) exp_pc = r_tgt & ~32'h1;
      if (r_rst) exp_pc = 32'h14;
      post_flush = r_rst || r_brv;
      hold_chk = !r_rst && !r_brv && bus0.out_valid && !r_rdy;
      hold_pc = bus0.out_pc;
      hold_instr = bus0.out_instr;
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
